// File: rtl/ct_convert_ctrl.sv
// Cell-state (Ct) conversion sequencer: fetch, load, convert and write N_UNITS elements per run.
// Optional saturation counter port sat_cnt is built when CT_CONVERT_CTRL_SAT_COUNT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, no run in progress
// S_FETCH | read strobe issued for the current element
// S_LOAD  | source data captured into the converter operand registers
// S_CONV  | converter in CTXT_CONVERT mode, result captured
// S_WRITE | Ct byte offered to the sink until accepted
// S_DONE  | one-cycle run-complete pulse
module ct_convert_ctrl #(
  parameter int N_UNITS = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       inpdt_data,
  input  logic [7:0]        bias_data,
  output logic [2:0]        lstm_state,
  output logic [31:0]       inpdt_R_reg,
  output logic [7:0]        bias_buffer,
  input  logic [7:0]        Ct_sat,
  output logic              ct_wr_en,
  output logic [ADDR_W-1:0] ct_wr_addr,
  output logic [7:0]        ct_wr_data,
  input  logic              ct_wr_ready
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
  ,
  output logic [ADDR_W:0]   sat_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CONV  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]        LSTM_IDLE    = 3'd0;
  localparam logic [2:0]        CTXT_CONVERT = 3'd4;
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(N_UNITS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] elem_idx, elem_idx_nxt;
  logic              start_acc;
  logic              load_en;
  logic              conv_en;

  assign start_acc = (state == S_IDLE) && start && !abort;
  assign rd_addr   = elem_idx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      elem_idx <= '0;
    end else begin
      state    <= state_nxt;
      elem_idx <= elem_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    elem_idx_nxt = elem_idx;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    ct_wr_en     = 1'b0;
    lstm_state   = LSTM_IDLE;
    load_en      = 1'b0;
    conv_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          elem_idx_nxt = '0;
          state_nxt    = S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        load_en   = 1'b1;
        state_nxt = S_CONV;
      end
      S_CONV: begin
        busy       = 1'b1;
        lstm_state = CTXT_CONVERT;
        conv_en    = 1'b1;
        state_nxt  = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        ct_wr_en = 1'b1;
        if (ct_wr_ready) begin
          if (elem_idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            elem_idx_nxt = elem_idx + 1'b1;
            state_nxt    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything: strobes are withheld so the sink never sees a half-cancelled write.
    if (abort) begin
      state_nxt    = S_IDLE;
      elem_idx_nxt = elem_idx;
      rd_en        = 1'b0;
      ct_wr_en     = 1'b0;
      done         = 1'b0;
      load_en      = 1'b0;
      conv_en      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inpdt_R_reg <= '0;
      bias_buffer <= '0;
      ct_wr_addr  <= '0;
      ct_wr_data  <= '0;
    end else begin
      if (load_en) begin
        inpdt_R_reg <= inpdt_data;
        bias_buffer <= bias_data;
      end
      if (conv_en) begin
        ct_wr_data <= Ct_sat;
        ct_wr_addr <= elem_idx;
      end
    end
  end

`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sat_cnt <= '0;
    end else if (start_acc) begin
      sat_cnt <= '0;
    end else if (conv_en && ((Ct_sat == 8'd0) || (Ct_sat == 8'd255))) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ct_convert_ctrl.sv
// Self-checking bench for ct_convert_ctrl with a behavioural source memory and Ct converter.
module tb_ct_convert_ctrl;
  localparam int N  = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          resetn, start, abort;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   inpdt_data;
  logic [7:0]    bias_data;
  logic [2:0]    lstm_state;
  logic [31:0]   inpdt_R_reg;
  logic [7:0]    bias_buffer;
  logic [7:0]    Ct_sat;
  logic          ct_wr_en;
  logic [AW-1:0] ct_wr_addr;
  logic [7:0]    ct_wr_data;
  logic          ct_wr_ready;
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
  logic [AW:0]   sat_cnt;
`endif

  always #5 clk = ~clk;

  ct_convert_ctrl #(.N_UNITS(N), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .inpdt_data(inpdt_data), .bias_data(bias_data),
    .lstm_state(lstm_state), .inpdt_R_reg(inpdt_R_reg), .bias_buffer(bias_buffer),
    .Ct_sat(Ct_sat),
    .ct_wr_en(ct_wr_en), .ct_wr_addr(ct_wr_addr), .ct_wr_data(ct_wr_data),
    .ct_wr_ready(ct_wr_ready)
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_inpdt [4];
  logic [7:0]  mem_bias  [4];

  // Converter: Ct = sat8(128 + bias/2 + inpdt/128), only meaningful in CTXT_CONVERT mode.
  function automatic logic [7:0] conv_model(input logic [31:0] ip, input logic [7:0] b);
    int v;
    v = 128 + int'(b >> 1) + ($signed(ip) >>> 7);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  assign Ct_sat = (lstm_state == 3'd4) ? conv_model(inpdt_R_reg, bias_buffer) : 8'h00;

  // Source memory with one-cycle read latency; garbage when not strobed.
  always @(posedge clk) begin
    if (rd_en) begin
      inpdt_data <= mem_inpdt[rd_addr];
      bias_data  <= mem_bias[rd_addr];
    end else begin
      inpdt_data <= $urandom;
      bias_data  <= 8'($urandom);
    end
  end

  logic [AW-1:0] got_a[$];
  logic [7:0]    got_d[$];
  int            done_k, done_cnt, stalls, stab_err, range_err;
  logic [5:0]    after_abort;

  // rmode: 0 ready always, 1 random ready, 2 first write stalled 5 cycles
  task automatic run_case(input int rmode, input int abort_k, input int start2_k, input int max_k);
    logic          pend;
    logic [AW-1:0] pa;
    logic [7:0]    pd;
    int            stall_left;
    got_a.delete(); got_d.delete();
    done_k = -1; done_cnt = 0; stalls = 0; stab_err = 0; range_err = 0;
    after_abort = 6'h3f;
    pend = 1'b0; pa = '0; pd = '0; stall_left = 5;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; ct_wr_ready = 1'b1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      start = (k == start2_k);
      abort = (k == abort_k);
      if (rmode == 0) ct_wr_ready = 1'b1;
      else if (rmode == 1) ct_wr_ready = 1'($urandom_range(0, 1));
      else if (ct_wr_en && stall_left > 0) begin
        ct_wr_ready = 1'b0;
        stall_left--;
      end else ct_wr_ready = 1'b1;
      #1;
      if (pend && !(ct_wr_en === 1'b1 && ct_wr_addr === pa && ct_wr_data === pd)) stab_err++;
      pend = ct_wr_en && !ct_wr_ready;
      pa = ct_wr_addr;
      pd = ct_wr_data;
      if (ct_wr_en && !ct_wr_ready) stalls++;
      if (ct_wr_en && ct_wr_ready) begin
        got_a.push_back(ct_wr_addr);
        got_d.push_back(ct_wr_data);
      end
      if ((rd_en && int'(rd_addr) > N - 1) || (ct_wr_en && int'(ct_wr_addr) > N - 1)) range_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == abort_k + 1) after_abort = {busy, ct_wr_en, rd_en, done, lstm_state[2], ct_wr_ready & 1'b0};
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; ct_wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; ct_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, lstm_state, inpdt_R_reg, bias_buffer, ct_wr_en, ct_wr_addr, ct_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b rd_addr=%0d lstm=%0d inpdt=%0h bias=%0h wr_en=%b wr_addr=%0d wr_data=%0h exp all 0",
               busy, done, rd_en, rd_addr, lstm_state, inpdt_R_reg, bias_buffer, ct_wr_en, ct_wr_addr, ct_wr_data);
    end
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
    checks++;
    if (sat_cnt !== '0) begin errors++; $display("FAIL reset_sat_cnt got=%0d exp=0", sat_cnt); end
`endif
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    mem_inpdt[0] = 32'd0; mem_inpdt[1] = 32'd0;
    mem_bias[0]  = 8'd0;  mem_bias[1]  = 8'd200;
    run_case(0, -1, -1, 16);
    checks++;
    if (got_a.size() !== 2) begin errors++; $display("FAIL basic_write_count got=%0d exp=2", got_a.size()); end
    checks++;
    if (got_a[0] !== 2'd0 || got_d[0] !== 8'd128) begin
      errors++; $display("FAIL basic_write0 got=(%0d,%0d) exp=(0,128)", got_a[0], got_d[0]);
    end
    checks++;
    if (got_a[1] !== 2'd1 || got_d[1] !== 8'd228) begin
      errors++; $display("FAIL basic_write1 got=(%0d,%0d) exp=(1,228)", got_a[1], got_d[1]);
    end
    checks++;
    if (done_k !== 9 || done_cnt !== 1) begin
      errors++; $display("FAIL basic_done got cycle=%0d count=%0d exp cycle=9 count=1", done_k, done_cnt);
    end
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
    checks++;
    if (sat_cnt !== 3'd0) begin errors++; $display("FAIL basic_sat_cnt got=%0d exp=0", sat_cnt); end
`endif
  endtask

  task automatic test_saturation();
    mem_inpdt[0] = 32'd25600; mem_inpdt[1] = -32'sd25600;
    mem_bias[0]  = 8'd0;      mem_bias[1]  = 8'd0;
    run_case(0, -1, -1, 16);
    checks++;
    if (got_a.size() !== 2 || got_a[0] !== 2'd0 || got_d[0] !== 8'd255 || got_a[1] !== 2'd1 || got_d[1] !== 8'd0) begin
      errors++;
      $display("FAIL sat_writes got n=%0d (%0d,%0d) (%0d,%0d) exp n=2 (0,255) (1,0)",
               got_a.size(), got_a[0], got_d[0], got_a[1], got_d[1]);
    end
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
    checks++;
    if (sat_cnt !== 3'd2) begin errors++; $display("FAIL sat_cnt got=%0d exp=2", sat_cnt); end
`endif
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) begin
      mem_inpdt[i] = 32'($urandom_range(0, 60000)) - 32'd30000;
      mem_bias[i]  = 8'($urandom);
    end
    run_case(2, -1, -1, 24);
    checks++;
    if (stab_err !== 0 || stalls !== 5) begin
      errors++; $display("FAIL stall_hold got unstable=%0d stalls=%0d exp unstable=0 stalls=5", stab_err, stalls);
    end
    checks++;
    if (done_k !== 14 || done_cnt !== 1) begin
      errors++; $display("FAIL stall_done got cycle=%0d count=%0d exp cycle=14 count=1", done_k, done_cnt);
    end
    checks++;
    if (got_d.size() !== 2 || got_d[0] !== conv_model(mem_inpdt[0], mem_bias[0])
        || got_d[1] !== conv_model(mem_inpdt[1], mem_bias[1])) begin
      errors++; $display("FAIL stall_data got n=%0d d0=%0d d1=%0d exp d0=%0d d1=%0d", got_d.size(), got_d[0], got_d[1],
                         conv_model(mem_inpdt[0], mem_bias[0]), conv_model(mem_inpdt[1], mem_bias[1]));
    end
  endtask

  task automatic test_random();
    int exp_sat;
    logic [7:0] e;
    for (int r = 0; r < 8; r++) begin
      exp_sat = 0;
      for (int i = 0; i < N; i++) begin
        mem_inpdt[i] = 32'($urandom_range(0, 80000)) - 32'd40000;
        mem_bias[i]  = 8'($urandom);
      end
      run_case(1, -1, -1, 60);
      checks++;
      if (got_a.size() !== N) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_a.size(), N); end
      for (int i = 0; i < N; i++) begin
        e = conv_model(mem_inpdt[i], mem_bias[i]);
        if (e == 8'd0 || e == 8'd255) exp_sat++;
        checks++;
        if (got_a[i] !== AW'(i) || got_d[i] !== e) begin
          errors++; $display("FAIL rand%0d_write%0d got=(%0d,%0d) exp=(%0d,%0d)", r, i, got_a[i], got_d[i], i, e);
        end
      end
      checks++;
      if (done_cnt !== 1 || done_k !== 4 * N + 1 + stalls || stab_err !== 0 || range_err !== 0) begin
        errors++; $display("FAIL rand%0d_timing got done=%0d@%0d unstable=%0d range=%0d exp done=1@%0d",
                           r, done_cnt, done_k, stab_err, range_err, 4 * N + 1 + stalls);
      end
`ifdef CT_CONVERT_CTRL_SAT_COUNT_EN
      checks++;
      if (sat_cnt !== (AW + 1)'(exp_sat)) begin errors++; $display("FAIL rand%0d_sat_cnt got=%0d exp=%0d", r, sat_cnt, exp_sat); end
`endif
    end
  endtask

  task automatic test_abort();
    mem_inpdt[0] = 32'd1280; mem_inpdt[1] = 32'd2560;
    mem_bias[0]  = 8'd10;    mem_bias[1]  = 8'd20;
    run_case(0, 7, -1, 20);
    checks++;
    if (after_abort !== 6'b0) begin
      errors++; $display("FAIL abort_idle got {busy,wr_en,rd_en,done,conv}=%b exp 0", after_abort[5:1]);
    end
    checks++;
    if (got_a.size() !== 1 || got_a[0] !== 2'd0 || done_cnt !== 0) begin
      errors++; $display("FAIL abort_writes got n=%0d done=%0d exp n=1 done=0", got_a.size(), done_cnt);
    end
    run_case(0, -1, -1, 16);
    checks++;
    if (got_a.size() !== 2 || got_a[0] !== 2'd0 || got_d[0] !== 8'd143 || got_d[1] !== 8'd158 || done_k !== 9) begin
      errors++; $display("FAIL abort_restart got n=%0d a0=%0d d0=%0d d1=%0d done@%0d exp n=2 a0=0 d0=143 d1=158 done@9",
                         got_a.size(), got_a[0], got_d[0], got_d[1], done_k);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_case(0, -1, 5, 24);
    checks++;
    if (done_cnt !== 1 || done_k !== 9 || got_a.size() !== 2) begin
      errors++; $display("FAIL start_busy got done=%0d@%0d writes=%0d exp done=1@9 writes=2", done_cnt, done_k, got_a.size());
    end
    bad = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL start_abort_idle got active_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    mem_inpdt[0] = 32'h0000_4a00; mem_bias[0] = 8'h5c;
    mem_inpdt[1] = 32'h0000_1100; mem_bias[1] = 8'h33;
    @(negedge clk);
    start = 1'b1; ct_wr_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    checks++;
    if (ct_wr_en !== 1'b1) begin errors++; $display("FAIL rst_pre_write got wr_en=%b exp=1", ct_wr_en); end
    resetn = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, lstm_state, inpdt_R_reg, bias_buffer, ct_wr_en, ct_wr_addr, ct_wr_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got busy=%b wr_en=%b inpdt=%0h bias=%0h wr_data=%0h exp all 0",
               busy, ct_wr_en, inpdt_R_reg, bias_buffer, ct_wr_data);
    end
    resetn = 1'b1; ct_wr_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || ct_wr_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_mid_quiet got active_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; ct_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_inpdt[i] = '0;
      mem_bias[i]  = '0;
    end
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_random();
    test_abort();
    test_start_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_convert_ctrl.md
CT_CONVERT_CTRL -- requirements
Module: ct_convert_ctrl

Interface
REQ-001 SHALL have parameter N_UNITS, default 32: number of cell-state elements converted per run, valid range 2..2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 5: element address width.
REQ-003 SHALL use one clock and a synchronous, active-low reset, exactly as follows: clk  in  1  rising-edge clock for all state; resetn  in  1  synchronous active-low reset.
REQ-004 SHALL have these control ports: start  in  1  run request; abort  in  1  synchronous cancel; busy  out  1  run in progress; done  out  1  one-cycle run-complete pulse.
REQ-005 SHALL have these source-memory ports: rd_en  out  1  read strobe; rd_addr  out  ADDR_W  element index; inpdt_data  in  32  signed inner-product sum, valid 1 cycle after rd_en; bias_data  in  8  bias byte, valid 1 cycle after rd_en.
REQ-006 SHALL have these converter ports: lstm_state  out  3  converter mode; inpdt_R_reg  out  32  registered inner-product operand; bias_buffer  out  8  registered bias operand; Ct_sat  in  8  saturated converter result (combinational from the three outputs above).
REQ-007 SHALL have these Ct-buffer write ports: ct_wr_en  out  1  write valid; ct_wr_addr  out  ADDR_W  destination index; ct_wr_data  out  8  Ct byte; ct_wr_ready  in  1  sink accepts.

Function
REQ-008 SHALL implement the FSM states IDLE, FETCH, LOAD, CONV, WRITE and DONE.
REQ-009 SHALL, in IDLE with start=1 and abort=0, clear the index to 0 and enter FETCH; start SHALL be ignored in every other state.
REQ-010 SHALL, in FETCH, drive rd_en=1 and rd_addr=index, then enter LOAD.
REQ-011 SHALL, in LOAD, register inpdt_data into inpdt_R_reg and bias_data into bias_buffer, then enter CONV.
REQ-012 SHALL drive lstm_state=3'd4 (CTXT_CONVERT) only while in CONV, and 3'd0 (IDLE) in all other states.
REQ-013 SHALL, in CONV, register Ct_sat into ct_wr_data and index into ct_wr_addr, then enter WRITE.
REQ-014 SHALL hold ct_wr_en=1 throughout WRITE, with ct_wr_addr and ct_wr_data stable, until a cycle with ct_wr_ready=1.
REQ-015 SHALL, on write acceptance, enter DONE if index==N_UNITS-1, otherwise increment index and enter FETCH.
REQ-016 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-017 SHALL drive busy=1 in FETCH, LOAD, CONV and WRITE, and busy=0 in IDLE and DONE.
REQ-018 SHALL take 4 cycles per element when ct_wr_ready is held at 1, so done is high in cycle 4*N_UNITS+1, where cycle 0 is the cycle in which start is sampled.
REQ-019 SHALL, when abort=1 in any state, return to IDLE on the next edge with no done pulse, ct_wr_en=0 and rd_en=0; abort SHALL take priority over start and over ct_wr_ready.
REQ-020 SHALL leave inpdt_R_reg, bias_buffer, ct_wr_addr and ct_wr_data holding their last values outside LOAD/CONV.
REQ-021 SHALL never exceed N_UNITS-1 on rd_addr or ct_wr_addr, and the index SHALL not wrap within a run.

Reset
REQ-022 SHALL, on resetn=0 sampled at a rising clk edge, enter IDLE with index=0.
REQ-023 SHALL drive these values while in reset: busy=0, done=0, rd_en=0, rd_addr=0, lstm_state=3'd0, inpdt_R_reg=0, bias_buffer=0, ct_wr_en=0, ct_wr_addr=0, ct_wr_data=0, plus sat_cnt=0 when present.
REQ-024 SHALL, if reset is asserted mid-run, discard the run with no done pulse and no further writes.

Configuration
REQ-025 SHALL, when macro CT_CONVERT_CTRL_SAT_COUNT_EN is defined, add output port sat_cnt (ADDR_W+1 bits) that is cleared on an accepted start and incremented in each CONV cycle where Ct_sat==8'd0 or Ct_sat==8'd255.
REQ-026 SHALL, when CT_CONVERT_CTRL_SAT_COUNT_EN is undefined, omit the sat_cnt port and its logic entirely, with all other behaviour identical.

Verification
REQ-027 SHALL pass this case: N_UNITS=2, ready=1, inpdt={0,0}, bias={0,200} -> writes (0,128) then (1,228); done high in cycle 9; sat_cnt=0.
REQ-028 SHALL pass this case: inpdt={25600,-25600}, bias={0,0} -> writes (0,255) then (1,0); sat_cnt=2 when the macro is defined.
REQ-029 SHALL pass this case: ct_wr_ready held 0 for 5 cycles during the first WRITE -> ct_wr_en, ct_wr_addr and ct_wr_data stable for 6 cycles, and done is delayed by 5 cycles.
REQ-030 SHALL pass this case: abort pulsed during element 1 CONV -> next cycle IDLE, busy=0, no element-1 write, no done; a new start restarts from address 0.
REQ-031 SHALL pass this case: start pulsed while busy, and start with abort together in IDLE -> both ignored, with no extra run.
REQ-032 SHALL pass this case: resetn=0 asserted during WRITE -> ct_wr_en=0 and all outputs at reset values on the next edge, with no done pulse.
